// File: rtl/y86_pipe_ctrl_gen.sv
// y86_pipe_ctrl_gen: Y86-64 five-stage pipeline controller.
// It decodes the load/use, ret, mispredict and exception hazards, handles a
// variable-latency data-memory handshake with a watchdog, keeps sticky
// HALTED/TIMEOUT states and counts cycles, stalls and mispredicts.
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   D_icode, d_srcA, d_srcB     decode-stage icode and source registers
//   E_icode, E_dstM, e_cnd      execute-stage icode, load destination and branch condition
//   M_icode, m_stat, W_stat     memory-stage icode/status and writeback status
//   dmem_ack / dmem_req         data-memory completion in, access request out
//   *_stall, *_bubble           controls for the F/D/E/M/W stage registers
//   ctrl_state                  0 RUN, 1 MEMWAIT, 2 HALTED, 3 TIMEOUT
//   cyc_cnt, stall_cnt, mispred_cnt  saturating performance counters
module y86_pipe_ctrl_gen #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_stall,
  output logic             E_bubble,
  output logic             M_stall,
  output logic             M_bubble,
  output logic             W_bubble,
  output logic             W_stall,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TMO     = 2'd3
  } state_t;

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] STAT_AOK = 3'd1;

  state_t            state, stateNext;
  logic [TO_W-1:0]   waitCnt, waitNext;

  logic memOp, active, loadUse, retPend, mispred, excM, excW;
  logic runMemStall, holdMem;

  assign ctrl_state = state;

  always_comb begin
    memOp   = (M_icode == 4'h4) || (M_icode == 4'h5) || (M_icode == 4'h8) ||
              (M_icode == 4'h9) || (M_icode == 4'hA) || (M_icode == 4'hB);
    active  = (state == ST_RUN) || (state == ST_MEMWAIT);
    dmem_req = !rst && active && memOp && (m_stat == STAT_AOK);

    loadUse = ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != RNONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    retPend = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    mispred = (E_icode == 4'h7) && !e_cnd;
    excM    = (m_stat == 3'd2) || (m_stat == 3'd3) || (m_stat == 3'd4);
    excW    = (W_stat == 3'd2) || (W_stat == 3'd3) || (W_stat == 3'd4);

    // A writeback exception wins over starting a memory wait: the pipe is
    // about to halt, so there is no point freezing it for the access.
    runMemStall = (state == ST_RUN) && dmem_req && !dmem_ack && !excW;
    holdMem     = runMemStall || ((state == ST_MEMWAIT) && !dmem_ack);

    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_stall  = 1'b0;
    E_bubble = 1'b0;
    M_stall  = 1'b0;
    M_bubble = 1'b0;
    W_bubble = 1'b0;
    W_stall  = 1'b0;

    if (!rst) begin
      if ((state == ST_HALTED) || (state == ST_TMO)) begin
        F_stall = 1'b1;
        D_stall = 1'b1;
        E_stall = 1'b1;
        M_stall = 1'b1;
        W_stall = 1'b1;
      end else if (holdMem) begin
        // Freeze F..M around the outstanding access; drain W with a bubble.
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_stall  = 1'b1;
        M_stall  = 1'b1;
        W_bubble = 1'b1;
      end else begin
        F_stall  = loadUse | retPend;
        D_stall  = loadUse;
        D_bubble = mispred | (retPend & !loadUse);
        E_bubble = mispred | loadUse;
        M_bubble = excM | excW;
        W_stall  = excW;
      end
    end

    stateNext = state;
    waitNext  = '0;
    case (state)
      ST_RUN: begin
        if (excW)             stateNext = ST_HALTED;
        else if (runMemStall) stateNext = ST_MEMWAIT;
      end
      ST_MEMWAIT: begin
        if (dmem_ack)                              stateNext = ST_RUN;
        else if (waitCnt == TO_W'(TIMEOUT - 1))    stateNext = ST_TMO;
        else                                       waitNext  = waitCnt + TO_W'(1);
      end
      default: stateNext = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RUN;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitNext;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt     <= '0;
      stall_cnt   <= '0;
      mispred_cnt <= '0;
    end else begin
      if (active && (cyc_cnt != '1))
        cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (active && F_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((state == ST_RUN) && mispred && !runMemStall && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_y86_pipe_ctrl_gen.sv
// Bench for y86_pipe_ctrl_gen: one default-width instance and one CNT_W=4
// instance share the same stimulus; a queue-based scoreboard checks both
// against a cycle-level reference model of the controller rules.
module tb_y86_pipe_ctrl_gen;

  localparam int TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [3:0] D_icode = 4'h1, d_srcA = 4'hF, d_srcB = 4'hF;
  logic [3:0] E_icode = 4'h1, E_dstM = 4'hF, M_icode = 4'h1;
  logic       e_cnd = 1'b1, dmem_ack = 1'b1;
  logic [2:0] m_stat = 3'd1, W_stat = 3'd1;

  logic        reqA, fsA, dsA, dbA, esA, ebA, msA, mbA, wbA, wsA;
  logic [1:0]  stA;
  logic [31:0] cycA, stlA, misA;
  logic        reqB, fsB, dsB, dbB, esB, ebB, msB, mbB, wbB, wsB;
  logic [1:0]  stB;
  logic [3:0]  cycB, stlB, misB;

  y86_pipe_ctrl_gen #(.CNT_W(32), .TIMEOUT(TMO), .TO_W(5)) dutA (
    .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .dmem_ack(dmem_ack), .dmem_req(reqA),
    .F_stall(fsA), .D_stall(dsA), .D_bubble(dbA), .E_stall(esA), .E_bubble(ebA),
    .M_stall(msA), .M_bubble(mbA), .W_bubble(wbA), .W_stall(wsA),
    .ctrl_state(stA), .cyc_cnt(cycA), .stall_cnt(stlA), .mispred_cnt(misA));

  y86_pipe_ctrl_gen #(.CNT_W(4), .TIMEOUT(TMO), .TO_W(5)) dutB (
    .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .dmem_ack(dmem_ack), .dmem_req(reqB),
    .F_stall(fsB), .D_stall(dsB), .D_bubble(dbB), .E_stall(esB), .E_bubble(ebB),
    .M_stall(msB), .M_bubble(mbB), .W_bubble(wbB), .W_stall(wsB),
    .ctrl_state(stB), .cyc_cnt(cycB), .stall_cnt(stlB), .mispred_cnt(misB));

  // ctl = {F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_bubble, W_stall, dmem_req}
  typedef struct {
    logic [9:0] ctl;
    int         st;
    longint     cyc, stl, mis;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  // Reference model: controller mode, cycles spent waiting, unbounded event counts.
  int     mState = 0;
  int     mWaited = 0;
  longint mCyc = 0, mStl = 0, mMis = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic longint sat4(input longint x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic drive(input logic r, input logic [3:0] di, input logic [3:0] sa,
                       input logic [3:0] sb, input logic [3:0] ei, input logic [3:0] edm,
                       input logic ec, input logic [3:0] mi, input logic [2:0] ms,
                       input logic [2:0] ws, input logic ack);
    exp_t e;
    bit memOp, req, lu, rp, mp, em, ew, frozen, halted;
    bit f, ds, db, es, eb, mst, mb, wb, wst;
    @(negedge clk);
    rst = r; D_icode = di; d_srcA = sa; d_srcB = sb; E_icode = ei; E_dstM = edm;
    e_cnd = ec; M_icode = mi; m_stat = ms; W_stat = ws; dmem_ack = ack;
    if (r) begin
      mState = 0; mWaited = 0; mCyc = 0; mStl = 0; mMis = 0;
      e.ctl = '0; e.st = 0; e.cyc = 0; e.stl = 0; e.mis = 0;
      sbq.push_back(e);
    end else begin
      halted = (mState >= 2);
      memOp  = (mi inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB});
      req    = !halted && memOp && (ms == 3'd1);
      lu     = (ei inside {4'h5, 4'hB}) && (edm != 4'hF) && (edm == sa || edm == sb);
      rp     = (di == 4'h9) || (ei == 4'h9) || (mi == 4'h9);
      mp     = (ei == 4'h7) && !ec;
      em     = (ms inside {3'd2, 3'd3, 3'd4});
      ew     = (ws inside {3'd2, 3'd3, 3'd4});
      frozen = !halted && !ack && ((mState == 1) || (req && !ew));
      {f, ds, db, es, eb, mst, mb, wb, wst} = '0;
      if (halted) begin
        f = 1; ds = 1; es = 1; mst = 1; wst = 1;
      end else if (frozen) begin
        f = 1; ds = 1; es = 1; mst = 1; wb = 1;
      end else begin
        f = lu || rp; ds = lu; db = mp || (rp && !lu); eb = mp || lu;
        mb = em || ew; wst = ew;
      end
      e.ctl = {f, ds, db, es, eb, mst, mb, wb, wst, req};
      e.st = mState; e.cyc = mCyc; e.stl = mStl; e.mis = mMis;
      sbq.push_back(e);
      // Advance across the clock edge.
      if (!halted) begin
        mCyc++;
        if (f) mStl++;
      end
      if (mState == 0 && mp && !frozen) mMis++;
      if (mState == 0) begin
        if (ew) mState = 2;
        else if (frozen) begin mState = 1; mWaited = 1; end
      end else if (mState == 1) begin
        if (ack) begin mState = 0; mWaited = 0; end
        else if (mWaited >= TMO) mState = 3;
        else mWaited++;
      end
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++)
      drive(0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 4'h1, 3'd1, 3'd1, 1);
  endtask

  task automatic doReset();
    drive(1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 4'h1, 3'd1, 3'd1, 1);
  endtask

  function automatic logic [3:0] rreg();
    return ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 3));
  endfunction

  // Monitor: outputs are valid every cycle, sampled 2 time units after the driver.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("ctl",       {fsA, dsA, dbA, esA, ebA, msA, mbA, wbA, wsA, reqA}, e.ctl);
        check("state",     stA, e.st);
        check("cyc_cnt",   cycA, e.cyc);
        check("stall_cnt", stlA, e.stl);
        check("mis_cnt",   misA, e.mis);
        check("ctl_w4",    {fsB, dsB, dbB, esB, ebB, msB, mbB, wbB, wsB, reqB}, e.ctl);
        check("cyc_w4",    cycB, sat4(e.cyc));
        check("stall_w4",  stlB, sat4(e.stl));
        check("mis_w4",    misB, sat4(e.mis));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic r, ack, ec;
    logic [2:0] ms, ws;
    doReset();
    doReset();

    // Load/use hazard with a zero-wait memory.
    drive(0, 4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1, 4'h1, 3'd1, 3'd1, 1);
    #3 check("lu_dstall", {dsA, dbA, ebA}, 3'b101);
    nop(2);

    // Mispredict, then a correctly predicted branch.
    drive(0, 4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 0, 4'h1, 3'd1, 3'd1, 1);
    #3 check("mp_bubbles", {dbA, ebA}, 2'b11);
    drive(0, 4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1, 4'h1, 3'd1, 3'd1, 1);
    nop(2);

    // Three-cycle memory latency.
    for (int k = 0; k < 3; k++)
      drive(0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 4'h5, 3'd1, 3'd1, 0);
    drive(0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 4'h5, 3'd1, 3'd1, 1);
    #3 check("mw_state_ack", stA, 2'd1);
    nop(3);

    // Watchdog timeout.
    doReset();
    for (int k = 0; k < 20; k++) begin
      drive(0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 4'h4, 3'd1, 3'd1, 0);
      #3;
      if (k == 16) check("tmo_pre", stA, 2'd1);
      if (k == 17) check("tmo_hit", stA, 2'd3);
      if (k == 19) check("tmo_hold", {fsA, wsA, reqA}, 3'b110);
    end

    // Halt on writeback exception, then asynchronous reset mid-cycle.
    doReset();
    nop(3);
    drive(0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 4'h1, 3'd1, 3'd2, 1);
    #3 check("halt_same", {wsA, mbA}, 2'b11);
    nop(4);
    doReset();
    #1 check("rst_async", {stA, cycA}, 34'd0);

    // Counter saturation on the narrow instance.
    for (int k = 0; k < 20; k++)
      drive(0, 4'h1, 4'h2, 4'hF, 4'hB, 4'h2, 1, 4'h1, 3'd1, 3'd1, 1);
    #3 check("sat_w4", {stlB, cycB}, 8'hFF);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      ec  = 1'($urandom_range(0, 1));
      ack = ($urandom_range(0, 3) != 0);
      ms  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      ws  = ($urandom_range(0, 79) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      drive(r, 4'($urandom_range(0, 11)), rreg(), rreg(), 4'($urandom_range(0, 11)),
            rreg(), ec, 4'($urandom_range(0, 11)), ms, ws, ack);
    end

    repeat (3) @(negedge clk);
    #3 check("drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y86_pipe_ctrl_gen.md
Name: y86_pipe_ctrl_gen

Overview: Parametrised, stateful successor to the five-stage Y86-64 pipeline controller. It keeps the combinational load/use, ret, mispredict and exception stall/bubble rules. It adds three things: a variable-latency data-memory handshake with a timeout watchdog, a sticky halt/error state, and saturating performance counters. It sits beside the F/D/E/M/W stage registers and drives all of their stall and bubble inputs.

Parameters:
CNT_W, 32, width of each performance counter
TIMEOUT, 16, maximum cycles M may wait for dmem_ack before an error is raised
TO_W, 5, width of the wait counter; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
D_icode  in  4  icode in the D stage
d_srcA  in  4  decode source A (4'hF = RNONE)
d_srcB  in  4  decode source B (4'hF = RNONE)
E_icode  in  4  icode in the E stage
E_dstM  in  4  E-stage memory destination register
e_cnd  in  1  branch condition evaluated in E
M_icode  in  4  icode in the M stage
m_stat  in  3  memory-stage status (1 AOK, 2 HLT, 3 ADR, 4 INS)
W_stat  in  3  writeback-stage status
dmem_ack  in  1  data memory has completed the current access
dmem_req  out  1  memory access request for the M-stage op
F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_bubble, W_stall  out  1 each  stage controls
ctrl_state  out  2  0 RUN, 1 MEMWAIT, 2 HALTED, 3 TIMEOUT
cyc_cnt, stall_cnt, mispred_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (async, any cycle): state goes to RUN, the wait counter and all counters clear to 0, and dmem_req is 0. All stall/bubble outputs are 0 during reset.
- Memory ops in M are icodes 4, 5, 8, 9, A and B. dmem_req = (state ∈ {RUN, MEMWAIT}) and M holds a memory op and m_stat == AOK. It is combinational.
- RUN state, base rules (combinational):
  - load_use = E_icode ∈ {5, B} and E_dstM ≠ F and E_dstM ∈ {d_srcA, d_srcB}.
  - ret_pend = 9 ∈ {D_icode, E_icode, M_icode}.
  - mispred = E_icode == 7 and !e_cnd.
  - F_stall = load_use | ret_pend.
  - D_stall = load_use.
  - D_bubble = mispred | (ret_pend & !load_use).
  - E_bubble = mispred | load_use.
  - exc_m = m_stat ∈ {2, 3, 4}; exc_w = W_stat ∈ {2, 3, 4}.
  - M_bubble = exc_m | exc_w.
  - W_stall = exc_w.
- Memory wait:
  - In RUN, dmem_req & !dmem_ack moves to MEMWAIT at the next edge. In that same cycle F/D/E/M stall, W_bubble is set, and base bubbles are suppressed.
  - A memory op with dmem_ack in the same cycle is zero-wait and stays in RUN.
  - In MEMWAIT the outputs are held: F/D/E/M stall, W_bubble = 1, all other bubbles 0, and the wait counter increments each cycle.
  - In MEMWAIT, dmem_ack returns to RUN at the next edge and clears the wait counter. During that ack cycle the base rules apply normally.
  - In MEMWAIT, if the wait counter reaches TIMEOUT-1 with no ack, the block moves to TIMEOUT at the next edge.
- HALTED: entered from RUN at the edge after exc_w. Exit is only by reset.
  - Outputs: F_stall = D_stall = E_stall = M_stall = W_stall = 1, all bubbles 0, dmem_req = 0.
  - exc_w takes priority over memory-wait entry.
- TIMEOUT: outputs are identical to HALTED; only the ctrl_state encoding differs. Exit is only by reset.
- Counters (saturate at all-ones, never wrap):
  - cyc_cnt increments every cycle in RUN or MEMWAIT.
  - stall_cnt increments each cycle F_stall = 1 in RUN or MEMWAIT.
  - mispred_cnt increments each RUN cycle where mispred = 1 and the pipe is not stalled for memory.
- Simultaneous events in RUN:
  - The memory-wait stall overrides load_use, ret and mispred. Because E is held, those conditions are re-evaluated after the wait.
  - load_use together with mispred cannot occur (both need E_icode).
  - load_use together with ret_pend gives D_stall, not D_bubble.

Test Plan:
1. Load/use: E_icode=5, E_dstM=3, d_srcA=3, dmem_ack=1 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0, stall_cnt +1.
2. Mispredict: E_icode=7, e_cnd=0, others NOP → D_bubble=1, E_bubble=1, mispred_cnt goes 0→1. With e_cnd=1 → all outputs 0.
3. Memory latency of 3: M_icode=5 with dmem_ack low for 3 cycles, then high:
   - ctrl_state=1 for 3 cycles, with F/D/E/M stall=1 and W_bubble=1.
   - The state returns to 0 the cycle after ack.
   - stall_cnt increases by 3.
4. Timeout: M_icode=4 with dmem_ack held at 0 → ctrl_state=3 exactly TIMEOUT+1 cycles after the request first asserts (17 cycles at the default), then all stalls stay 1 and dmem_req=0 indefinitely.
5. Halt: W_stat=2 in RUN:
   - Same cycle: W_stall=1 and M_bubble=1.
   - Next cycle: ctrl_state=2, and cyc_cnt freezes.
   - Asserting rst mid-cycle immediately gives ctrl_state=0 and all counters 0.
6. Saturation, run at CNT_W=4: hold load_use for 20 cycles → stall_cnt stops at 15 and cyc_cnt stops at 15.
